ring_code_monitor: RTL

RING_CODE_MONITOR -- requirements
Module: ring_code_monitor

---
 rtl/ring_pkg.sv | 18 +
 rtl/ring_code_monitor_if.sv | 32 +++
 rtl/ring_code_check.sv | 25 ++
 rtl/ring_code_monitor.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for the ring-counter code monitor: FSM states,
// the four legal one-hot codes and the default lock depth.
package ring_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    localparam logic [3:0] CODE_0 = 4'b0001;
    localparam logic [3:0] CODE_1 = 4'b0010;
    localparam logic [3:0] CODE_2 = 4'b0100;
    localparam logic [3:0] CODE_3 = 4'b1000;

    localparam int DEFAULT_LOCK_STEPS = 4;

endpackage

// File: rtl/ring_code_monitor_if.sv
// Bundle of the monitor's sampled input, status outputs and debug view.
interface ring_code_monitor_if
    import ring_pkg::*;
#(
    parameter int REV_W = 8
);
    // No handshake: ring_in is sampled on every clock edge and the status
    // outputs are valid every cycle; there is no valid/ready backpressure.
    logic [3:0]       ring_in;
    logic [1:0]       idx;
    logic             idx_valid;
    logic             locked;
    logic             err_illegal;
    logic             err_seq;
    logic [REV_W-1:0] rev_count;
    ring_state_e      dbg_state;
    logic [3:0]       dbg_step;
    logic [3:0]       dbg_next;

    modport master (
        output ring_in,
        input  idx, idx_valid, locked, err_illegal, err_seq, rev_count,
        input  dbg_state, dbg_step, dbg_next
    );

    modport slave (
        input  ring_in,
        output idx, idx_valid, locked, err_illegal, err_seq, rev_count,
        output dbg_state, dbg_step, dbg_next
    );

endinterface

// File: rtl/ring_code_check.sv
// Combinational decode of one 4-bit ring code: legality, binary position
// and the code that should follow it in the rotating sequence.
module ring_code_check
    import ring_pkg::*;
(
    input  logic [3:0] code,
    output logic       legal,
    output logic [1:0] idx,
    output logic [3:0] next_code
);

    always_comb begin
        legal     = 1'b1;
        idx       = 2'd0;
        next_code = {code[0], code[3:1]};
        case (code)
            CODE_0:  idx = 2'd0;
            CODE_1:  idx = 2'd1;
            CODE_2:  idx = 2'd2;
            CODE_3:  idx = 2'd3;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ring_code_monitor.sv
// Tracks a sampled 4-bit ring-counter code, declares lock after a run of
// valid transitions, flags illegal/out-of-order codes and counts revolutions.
module ring_code_monitor
    import ring_pkg::*;
#(
    parameter int LOCK_STEPS = DEFAULT_LOCK_STEPS,
    parameter int REV_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    ring_code_monitor_if.slave  bus
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_STEPS - 1);

    logic [3:0]       samp;
    logic [3:0]       prev;
    logic             primed;
    ring_state_e      state;
    logic [3:0]       step;
    logic [1:0]       idx_q;
    logic             idx_valid_q;
    logic             locked_q;
    logic             err_illegal_q;
    logic             err_seq_q;
    logic [REV_W-1:0] rev_q;

    logic             samp_legal;
    logic [1:0]       samp_idx;
    logic [3:0]       samp_next;
    logic             prev_legal;
    logic [1:0]       prev_idx;
    logic [3:0]       prev_next;
    logic             valid;

    ring_code_check u_samp_chk (
        .code      (samp),
        .legal     (samp_legal),
        .idx       (samp_idx),
        .next_code (samp_next)
    );

    ring_code_check u_prev_chk (
        .code      (prev),
        .legal     (prev_legal),
        .idx       (prev_idx),
        .next_code (prev_next)
    );

    // A stall fails this compare because the successor always differs from prev.
    assign valid = samp_legal && prev_legal && (samp == prev_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            samp          <= 4'd0;
            prev          <= 4'd0;
            primed        <= 1'b0;
            state         <= HUNT;
            step          <= 4'd0;
            idx_q         <= 2'd0;
            idx_valid_q   <= 1'b0;
            locked_q      <= 1'b0;
            err_illegal_q <= 1'b0;
            err_seq_q     <= 1'b0;
            rev_q         <= '0;
        end else begin
            samp   <= bus.ring_in;
            prev   <= samp;
            // The zero left in samp by reset is not a real sample, so it must not flag an error.
            primed <= 1'b1;

            idx_valid_q   <= samp_legal;
            if (samp_legal) idx_q <= samp_idx;
            err_illegal_q <= primed && !samp_legal;
            err_seq_q     <= (state == LOCKED) && samp_legal && !valid;

            case (state)
                HUNT: begin
                    if (samp_legal) begin
                        state <= CHECK;
                        step  <= 4'd0;
                    end
                end
                CHECK: begin
                    if (!samp_legal) begin
                        state <= HUNT;
                        step  <= 4'd0;
                    end else if (valid) begin
                        step <= step + 4'd1;
                        if (step == LOCK_LAST) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end else begin
                        step <= 4'd0;
                    end
                end
                LOCKED: begin
                    if (valid) begin
                        if (prev_idx == 2'd0) rev_q <= rev_q + 1'b1;
                    end else begin
                        state    <= HUNT;
                        step     <= 4'd0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= HUNT;
                    step     <= 4'd0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.idx         = idx_q;
    assign bus.idx_valid   = idx_valid_q;
    assign bus.locked      = locked_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_seq     = err_seq_q;
    assign bus.rev_count   = rev_q;
    assign bus.dbg_state   = state;
    assign bus.dbg_step    = step;
    assign bus.dbg_next    = samp_next;

endmodule
